// File: rtl/mips_multi_cycle.sv
// mips_multi_cycle: multi-cycle MIPS-subset core with one shared ALU and a
// unified instruction/data memory behind a req/ready handshake.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   mem_req/we/addr/wdata     registered memory request (held until mem_ready)
//   mem_rdata, mem_ready      memory response; a transfer completes on req && ready
//   dbg_reg_addr/dbg_reg_data combinational register-file peek ($0 reads 0)
//   pc_out                    current PC
//   halted, illegal           core stopped; illegal marks a trap
//   retired                   completed-instruction counter (wraps)
module mips_multi_cycle #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ready,
    input  logic [4:0]           dbg_reg_addr,
    output logic [31:0]          dbg_reg_data,
    output logic [31:0]          pc_out,
    output logic                 halted,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam int unsigned DW = 32;
    localparam int unsigned NREGS = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t          state;
    logic [DW-1:0]   pc;
    logic [DW-1:0]   ir;
    logic [DW-1:0]   a_reg;
    logic [DW-1:0]   b_reg;
    logic [DW-1:0]   alu_out;
    logic [DW-1:0]   mdr;
    logic [DW-1:0]   regs [NREGS];

    // Instruction fields
    logic [5:0]      op;
    logic [4:0]      rs, rt, rd;
    logic [5:0]      funct;
    logic [DW-1:0]   sext_imm;
    logic            unused_shamt;

    assign op           = ir[31:26];
    assign rs           = ir[25:21];
    assign rt           = ir[20:16];
    assign rd           = ir[15:11];
    assign funct        = ir[5:0];
    assign sext_imm     = {{16{ir[15]}}, ir[15:0]};
    assign unused_shamt = ^ir[10:6];

    // Opcode/funct legality (halt is recognised separately in DECODE)
    logic legal;
    always_comb begin
        legal = 1'b0;
        case (op)
            OP_RTYPE: legal = (funct == FN_ADD) || (funct == FN_SUB) ||
                              (funct == FN_AND) || (funct == FN_OR)  ||
                              (funct == FN_SLT);
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Shared ALU: R-type ops, or A + sext(imm) for addi and address generation
    logic [DW-1:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_res = a_reg + b_reg;
                    FN_SUB:  alu_res = a_reg - b_reg;
                    FN_AND:  alu_res = a_reg & b_reg;
                    FN_OR:   alu_res = a_reg | b_reg;
                    FN_SLT:  alu_res = DW'($signed(a_reg) < $signed(b_reg));
                    default: alu_res = '0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_res = a_reg + sext_imm;
            default: alu_res = '0;
        endcase
    end

    // Branch/jump targets; pc already holds the incremented PC during EXEC
    logic [DW-1:0] br_target;
    logic [DW-1:0] j_target;
    logic          br_taken;
    assign br_target = pc + {sext_imm[29:0], 2'b00};
    assign j_target  = {pc[31:28], ir[25:0], 2'b00};
    assign br_taken  = (op == OP_BEQ) ? (a_reg == b_reg) : (a_reg != b_reg);

    // Writeback selection
    logic [4:0]    wb_dest;
    logic [DW-1:0] wb_data;
    assign wb_dest = (op == OP_RTYPE) ? rd : rt;
    assign wb_data = (op == OP_LW) ? mdr : alu_out;

    assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? '0 : regs[dbg_reg_addr];
    assign pc_out       = pc;

    // Core sequencer; memory-bus outputs are loaded on entry to FETCH/MEM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_START;
            pc        <= RESET_PC;
            ir        <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            retired   <= '0;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_START: begin
                    state    <= S_FETCH;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= {pc[31:2], 2'b00};
                end

                S_FETCH: begin
                    if (mem_ready) begin
                        ir      <= mem_rdata;
                        pc      <= pc + DW'(4);
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    a_reg <= regs[rs];
                    b_reg <= regs[rt];
                    if (op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (!legal) begin
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        state <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    case (op)
                        OP_BEQ, OP_BNE: begin
                            if (br_taken) begin
                                pc       <= br_target;
                                mem_addr <= {br_target[31:2], 2'b00};
                            end else begin
                                mem_addr <= {pc[31:2], 2'b00};
                            end
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                            retired <= retired + CNT_WIDTH'(1);
                            state   <= S_FETCH;
                        end
                        OP_J: begin
                            pc       <= j_target;
                            mem_addr <= j_target;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            retired  <= retired + CNT_WIDTH'(1);
                            state    <= S_FETCH;
                        end
                        OP_LW, OP_SW: begin
                            alu_out <= alu_res;
                            if (alu_res[1:0] != 2'b00) begin
                                halted  <= 1'b1;
                                illegal <= 1'b1;
                                state   <= S_HALT;
                            end else begin
                                mem_req  <= 1'b1;
                                mem_we   <= (op == OP_SW);
                                mem_addr <= alu_res;
                                if (op == OP_SW) begin
                                    mem_wdata <= b_reg;
                                end
                                state <= S_MEM;
                            end
                        end
                        default: begin
                            alu_out <= alu_res;
                            state   <= S_WB;
                        end
                    endcase
                end

                S_MEM: begin
                    if (mem_ready) begin
                        if (op == OP_LW) begin
                            mdr     <= mem_rdata;
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            state   <= S_WB;
                        end else begin
                            // sw completes here; go straight into the next fetch
                            mem_we   <= 1'b0;
                            mem_addr <= {pc[31:2], 2'b00};
                            retired  <= retired + CNT_WIDTH'(1);
                            state    <= S_FETCH;
                        end
                    end
                end

                S_WB: begin
                    if (wb_dest != 5'd0) begin
                        regs[wb_dest] <= wb_data;
                    end
                    retired  <= retired + CNT_WIDTH'(1);
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= {pc[31:2], 2'b00};
                    state    <= S_FETCH;
                end

                S_HALT: begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    halted  <= 1'b1;
                end

                default: state <= S_START;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multi_cycle.sv
// tb_mips_multi_cycle: directed programs against mips_multi_cycle with a
// behavioural wait-state memory; a second instance checks RESET_PC override
// and asynchronous reset during a stalled fetch.
module tb_mips_multi_cycle;

    logic        clk;
    logic        reset_n;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data, pc_out, retired;
    logic        halted, illegal;

    logic        reset_n_b;
    logic        mem_req_b, mem_we_b, mem_ready_b;
    logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic [31:0] dbg_data_b, pc_out_b, retired_b;
    logic        halted_b, illegal_b;

    int checks = 0;
    int failures = 0;

    mips_multi_cycle u_dut (
        .clk(clk), .reset_n(reset_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .dbg_reg_addr(dbg_addr), .dbg_reg_data(dbg_data),
        .pc_out(pc_out), .halted(halted), .illegal(illegal), .retired(retired)
    );

    mips_multi_cycle #(.RESET_PC(32'h0000_0100)) u_dut_b (
        .clk(clk), .reset_n(reset_n_b),
        .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .mem_ready(mem_ready_b),
        .dbg_reg_addr(5'd0), .dbg_reg_data(dbg_data_b),
        .pc_out(pc_out_b), .halted(halted_b), .illegal(illegal_b), .retired(retired_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model for u_dut: 1 KiB, configurable wait states, bus monitor
    logic [31:0] mem [0:255];
    int          wait_cycles = 0;
    int          wcnt, req_len, req_count, wr_count, unstable, sw_len, lw_len;
    logic [31:0] wr_addr, wr_data, cap_addr, cap_wdata;
    logic        cap_we;
    logic [31:0] req_log [0:31];

    assign mem_rdata = mem[mem_addr[9:2]];
    assign mem_ready = mem_req && (wcnt >= wait_cycles);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt <= 0; req_len <= 0; req_count <= 0; wr_count <= 0;
            unstable <= 0; sw_len <= 0; lw_len <= 0;
            wr_addr <= '0; wr_data <= '0;
        end else if (mem_req) begin
            if (req_len == 0) begin
                cap_addr <= mem_addr; cap_we <= mem_we; cap_wdata <= mem_wdata;
            end else if (mem_addr !== cap_addr || mem_we !== cap_we ||
                         (mem_we && mem_wdata !== cap_wdata)) begin
                unstable <= unstable + 1;
            end
            if (mem_ready) begin
                wcnt    <= 0;
                req_len <= 0;
                if (req_count < 32) req_log[req_count[4:0]] <= mem_addr;
                req_count <= req_count + 1;
                if (mem_we) begin
                    mem[mem_addr[9:2]] <= mem_wdata;
                    wr_count <= wr_count + 1;
                    wr_addr  <= mem_addr;
                    wr_data  <= mem_wdata;
                    sw_len   <= req_len + 1;
                end else if (mem_addr == 32'h8) begin
                    lw_len <= req_len + 1;
                end
            end else begin
                wcnt    <= wcnt + 1;
                req_len <= req_len + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    localparam logic [31:0] HALT_INSN = 32'hFC00_0000;

    // Hold reset, clear memory, wait for the program words to be loaded
    task automatic reset_and_clear(input int waits);
        reset_n = 1'b0;
        wait_cycles = waits;
        @(negedge clk);
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        @(negedge clk);
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] word);
        mem[addr[9:2]] <= word;
    endtask

    // Release reset and run until halted; n = cycles from first FETCH to HALT
    task automatic run_to_halt(input string tag, output int n);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!halted && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_halted"}, 32'(halted), 32'd1);
    endtask

    task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
        dbg_addr = r;
        #1;
        v = dbg_data;
    endtask

    int          n;
    logic [31:0] v;
    int          hits;

    initial begin
        reset_n     = 1'b1;
        reset_n_b   = 1'b1;
        dbg_addr    = 5'd0;
        mem_ready_b = 1'b0;
        mem_rdata_b = HALT_INSN;
        #1;
        reset_n   = 1'b0;
        reset_n_b = 1'b0;

        // Arithmetic program, zero-wait memory
        reset_and_clear(0);
        load(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        load(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
        load(32'h08, enc_r(5'd1, 5'd2, 5'd3, 6'h20));
        load(32'h0C, enc_r(5'd2, 5'd1, 5'd4, 6'h2A));
        load(32'h10, HALT_INSN);
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_retired", retired, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        run_to_halt("arith", n);
        check("arith_cycles", 32'(n), 32'd18);
        read_reg(5'd1, v); check("arith_r1", v, 32'd5);
        read_reg(5'd2, v); check("arith_r2", v, 32'hFFFF_FFFD);
        read_reg(5'd3, v); check("arith_r3", v, 32'd2);
        read_reg(5'd4, v); check("arith_r4", v, 32'd1);
        check("arith_retired", retired, 32'd4);
        check("arith_illegal", 32'(illegal), 32'd0);
        check("arith_pc", pc_out, 32'h14);
        check("arith_halt_req", 32'(mem_req), 32'd0);

        // sw/lw with 3 wait cycles per request; code starts at 0x40 via j
        reset_and_clear(3);
        read_reg(5'd3, v); check("rst_regs_cleared", v, 32'd0);
        load(32'h00, {6'h02, 26'h10});
        load(32'h40, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        load(32'h44, enc_i(6'h2B, 5'd0, 5'd1, 16'd8));
        load(32'h48, enc_i(6'h23, 5'd0, 5'd5, 16'd8));
        load(32'h4C, HALT_INSN);
        run_to_halt("ldst", n);
        check("ldst_wr_count", 32'(wr_count), 32'd1);
        check("ldst_wr_addr", wr_addr, 32'h8);
        check("ldst_wr_data", wr_data, 32'd5);
        read_reg(5'd5, v); check("ldst_r5", v, 32'd5);
        check("ldst_sw_len", 32'(sw_len), 32'd4);
        check("ldst_lw_len", 32'(lw_len), 32'd4);
        check("ldst_stable", 32'(unstable), 32'd0);
        check("ldst_retired", retired, 32'd4);

        // Countdown loop with bne
        reset_and_clear(0);
        load(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd3));
        load(32'h04, enc_i(6'h08, 5'd1, 5'd1, 16'hFFFF));
        load(32'h08, enc_i(6'h05, 5'd1, 5'd0, 16'hFFFE));
        load(32'h0C, HALT_INSN);
        run_to_halt("loop", n);
        read_reg(5'd1, v); check("loop_r1", v, 32'd0);
        check("loop_retired", retired, 32'd7);
        check("loop_pc", pc_out, 32'h10);
        hits = 0;
        for (int i = 0; i < req_count && i < 32; i++) if (req_log[i] == 32'h4) hits++;
        check("loop_body_fetches", 32'(hits), 32'd3);

        // sub/and/or and taken beq skipping one instruction
        reset_and_clear(0);
        load(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd12));
        load(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'd10));
        load(32'h08, enc_r(5'd1, 5'd2, 5'd3, 6'h22));
        load(32'h0C, enc_r(5'd1, 5'd2, 5'd4, 6'h24));
        load(32'h10, enc_r(5'd1, 5'd2, 5'd5, 6'h25));
        load(32'h14, enc_i(6'h04, 5'd3, 5'd3, 16'd1));
        load(32'h18, enc_i(6'h08, 5'd0, 5'd6, 16'd1));
        load(32'h1C, HALT_INSN);
        run_to_halt("logic", n);
        read_reg(5'd3, v); check("logic_sub", v, 32'd2);
        read_reg(5'd4, v); check("logic_and", v, 32'd8);
        read_reg(5'd5, v); check("logic_or", v, 32'd14);
        read_reg(5'd6, v); check("logic_beq_skip", v, 32'd0);
        check("logic_retired", retired, 32'd6);
        check("logic_pc", pc_out, 32'h20);

        // Jump
        reset_and_clear(0);
        load(32'h00, {6'h02, 26'h10});
        load(32'h40, HALT_INSN);
        run_to_halt("jump", n);
        check("jump_req_count", 32'(req_count), 32'd2);
        check("jump_fetch0", req_log[0], 32'h0);
        check("jump_fetch1", req_log[1], 32'h40);
        check("jump_pc", pc_out, 32'h44);
        check("jump_retired", retired, 32'd1);

        // Illegal opcode trap
        reset_and_clear(0);
        load(32'h00, {6'h3E, 26'h0});
        run_to_halt("trap_op", n);
        check("trap_op_illegal", 32'(illegal), 32'd1);
        check("trap_op_retired", retired, 32'd0);

        // Misaligned load traps before any MEM request
        reset_and_clear(0);
        load(32'h00, enc_i(6'h23, 5'd0, 5'd1, 16'd2));
        run_to_halt("trap_lw", n);
        check("trap_lw_illegal", 32'(illegal), 32'd1);
        check("trap_lw_reqs", 32'(req_count), 32'd1);
        read_reg(5'd1, v); check("trap_lw_r1", v, 32'd0);

        // Writes to $0 are discarded
        reset_and_clear(0);
        load(32'h00, enc_i(6'h08, 5'd0, 5'd0, 16'd7));
        load(32'h04, HALT_INSN);
        run_to_halt("r0", n);
        read_reg(5'd0, v); check("r0_reads_zero", v, 32'd0);
        check("r0_illegal", 32'(illegal), 32'd0);
        check("r0_retired", retired, 32'd1);

        // Async reset during a stalled fetch on the RESET_PC=0x100 instance
        @(negedge clk);
        reset_n_b = 1'b1;
        @(posedge clk); #1;
        check("b_fetch_req", 32'(mem_req_b), 32'd1);
        check("b_fetch_addr", mem_addr_b, 32'h100);
        repeat (2) @(posedge clk);
        #3;
        reset_n_b = 1'b0;
        #1;
        check("b_async_drop", 32'(mem_req_b), 32'd0);
        check("b_rst_pc", pc_out_b, 32'h100);
        @(negedge clk);
        reset_n_b = 1'b1;
        @(posedge clk); #1;
        check("b_refetch_req", 32'(mem_req_b), 32'd1);
        check("b_refetch_addr", mem_addr_b, 32'h100);
        check("b_retired", retired_b, 32'd0);
        mem_ready_b = 1'b1;
        n = 0;
        while (!halted_b && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("b_halted", 32'(halted_b), 32'd1);
        check("b_illegal", 32'(illegal_b), 32'd0);
        check("b_final_pc", pc_out_b, 32'h104);
        check("b_final_retired", retired_b, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
